// File: rtl/poly_tone_mixer.sv
// ============================================================================
// poly_tone_mixer
// ----------------------------------------------------------------------------
// Polyphonic square-wave tone generator and mixer that feeds an audio codec's
// left/right sample inputs. Each of NUM_VOICES voices runs a programmable
// half-period divider that toggles a phase bit. On every rising edge of the
// codec's sample request the mixer snapshots the voices, sums the keyed and
// tuned ones one per cycle, saturates the sum to SAMPLE_W bits, applies an
// arithmetic volume shift and presents the result on LDATA/RDATA.
//
// Parameters
//   NUM_VOICES : number of tone voices (>= 2)
//   CNT_W      : half-period counter width
//   SAMPLE_W   : output sample width, two's complement
//   AMPLITUDE  : per-voice square-wave magnitude (positive)
//   HALF_INIT  : packed reset half-periods, voice i at [i*CNT_W +: CNT_W]
//
// Ports
//   Clk          in   system clock
//   Reset        in   asynchronous active-low reset
//   key_on       in   per-voice gate
//   sample_req   in   codec sample request level (edge-detected here)
//   cfg_we       in   half-period write strobe
//   cfg_voice    in   voice targeted by the write (out-of-range ignored)
//   cfg_half     in   new half-period, in Clk cycles minus one (0 = silent)
//   vol_shift    in   arithmetic right shift applied to the mixed sample
//   LDATA        out  left sample
//   RDATA        out  right sample, always equal to LDATA
//   sample_valid out  one-cycle pulse when LDATA/RDATA update
//   busy         out  mixer is accumulating or saturating
//   overrun      out  sticky flag: a sample request was dropped
// ============================================================================
module poly_tone_mixer #(
  parameter int                           NUM_VOICES = 15,
  parameter int                           CNT_W      = 20,
  parameter int                           SAMPLE_W   = 16,
  parameter logic [SAMPLE_W-1:0]          AMPLITUDE  = 16'h1000,
  parameter logic [NUM_VOICES*CNT_W-1:0]  HALF_INIT  = '0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_VOICES-1:0]         key_on,
  input  logic                          sample_req,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [CNT_W-1:0]              cfg_half,
  input  logic [1:0]                    vol_shift,
  output logic [SAMPLE_W-1:0]           LDATA,
  output logic [SAMPLE_W-1:0]           RDATA,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  // Headroom for NUM_VOICES full-scale contributions of either sign.
  localparam int ACC_W = SAMPLE_W + IDX_W + 1;

  localparam logic signed [ACC_W-1:0] AMP_EXT = ACC_W'(AMPLITUDE);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT
  } state_t;

  // --------------------------------------------------------------------------
  // Voice dividers
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]      half [NUM_VOICES];
  logic [CNT_W-1:0]      cnt  [NUM_VOICES];
  logic [NUM_VOICES-1:0] phase;
  logic [NUM_VOICES-1:0] half_nz;

  // NOTE: half/cnt are small register arrays, not RAM, so every element is
  // reset; HALF_INIT gives each voice a usable tuning straight out of reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        half[i] <= HALF_INIT[i*CNT_W +: CNT_W];
        cnt[i]  <= '0;
      end
      phase <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        // A retune restarts the count but leaves the phase where it is, so
        // the waveform does not glitch a half-cycle on every write.
        if (cfg_we && (cfg_voice == IDX_W'(i))) begin
          half[i] <= cfg_half;
          cnt[i]  <= '0;
        end else if (half[i] == '0) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= half[i]) begin
          cnt[i]   <= '0;
          phase[i] <= ~phase[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    half_nz = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      half_nz[i] = (half[i] != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Request edge detect
  // --------------------------------------------------------------------------
  logic req_q;
  logic req_edge;

  assign req_edge = sample_req & ~req_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= sample_req;
    end
  end

  // --------------------------------------------------------------------------
  // Saturation and volume
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] sat_val;
  logic signed [SAMPLE_W-1:0] scaled;

  always_comb begin
    sat_val = acc[SAMPLE_W-1:0];
    if (acc > SAT_MAX) begin
      sat_val = SAT_MAX[SAMPLE_W-1:0];
    end else if (acc < SAT_MIN) begin
      sat_val = SAT_MIN[SAMPLE_W-1:0];
    end
  end

  assign scaled = sat_val >>> vol_shift;

  // --------------------------------------------------------------------------
  // Mixer FSM
  // --------------------------------------------------------------------------
  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_VOICES-1:0] snap_key;
  logic [NUM_VOICES-1:0] snap_phase;
  logic [NUM_VOICES-1:0] snap_live;
  logic                  pending;
  logic                  voice_on;

  assign voice_on = snap_key[idx] & snap_live[idx];

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      snap_key     <= '0;
      snap_phase   <= '0;
      snap_live    <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      LDATA        <= '0;
      RDATA        <= '0;
    end else begin
      sample_valid <= 1'b0;

      // While the mixer is working, one request can wait in pending; any
      // further request before it is serviced is lost and flagged.
      if ((state != IDLE) && req_edge) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // A queued request waits out the cycle in which the previous
          // sample is presented, so back-to-back samples keep one idle
          // cycle between them. A new edge during that cycle has nowhere
          // to go and is dropped.
          if (pending && sample_valid) begin
            if (req_edge) begin
              overrun <= 1'b1;
            end
          end else if (req_edge || pending) begin
            snap_key   <= key_on;
            snap_phase <= phase;
            snap_live  <= half_nz;
            acc        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          if (voice_on) begin
            acc <= snap_phase[idx] ? (acc + AMP_EXT) : (acc - AMP_EXT);
          end
          if (idx == LAST_IDX) begin
            state <= SAT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        SAT: begin
          LDATA        <= scaled;
          RDATA        <= scaled;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_tone_mixer.sv
// ============================================================================
// tb_poly_tone_mixer
// ----------------------------------------------------------------------------
// Two instances with NUM_VOICES=4, CNT_W=8, SAMPLE_W=16, HALF_INIT={7,0,5,3}:
// dut_a uses AMPLITUDE=16'h1000, dut_b uses AMPLITUDE=16'h3000. Stimulus
// threads push the hand-computed sample and the cycle (counted in Clk edges
// since reset release) at which it must appear; a monitor per instance pops
// and compares whenever sample_valid is high.
// ============================================================================
module tb_poly_tone_mixer;

  localparam int NV = 4;
  localparam int CW = 8;
  localparam int SW = 16;
  localparam logic [NV*CW-1:0] HINIT = {8'd7, 8'd0, 8'd5, 8'd3};

  typedef struct {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [NV-1:0] a_key_on,    b_key_on;
  logic          a_req,       b_req;
  logic          a_cfg_we,    b_cfg_we;
  logic [1:0]    a_cfg_voice, b_cfg_voice;
  logic [CW-1:0] a_cfg_half,  b_cfg_half;
  logic [1:0]    a_vol,       b_vol;
  logic [SW-1:0] a_ldata,     b_ldata;
  logic [SW-1:0] a_rdata,     b_rdata;
  logic          a_valid,     b_valid;
  logic          a_busy,      b_busy;
  logic          a_overrun,   b_overrun;

  int   cyc;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  poly_tone_mixer #(
    .NUM_VOICES(NV), .CNT_W(CW), .SAMPLE_W(SW),
    .AMPLITUDE(16'h1000), .HALF_INIT(HINIT)
  ) dut_a (
    .Clk(clk), .Reset(rst_n), .key_on(a_key_on), .sample_req(a_req),
    .cfg_we(a_cfg_we), .cfg_voice(a_cfg_voice), .cfg_half(a_cfg_half),
    .vol_shift(a_vol), .LDATA(a_ldata), .RDATA(a_rdata),
    .sample_valid(a_valid), .busy(a_busy), .overrun(a_overrun)
  );

  poly_tone_mixer #(
    .NUM_VOICES(NV), .CNT_W(CW), .SAMPLE_W(SW),
    .AMPLITUDE(16'h3000), .HALF_INIT(HINIT)
  ) dut_b (
    .Clk(clk), .Reset(rst_n), .key_on(b_key_on), .sample_req(b_req),
    .cfg_we(b_cfg_we), .cfg_voice(b_cfg_voice), .cfg_half(b_cfg_half),
    .vol_shift(b_vol), .LDATA(b_ldata), .RDATA(b_rdata),
    .sample_valid(b_valid), .busy(b_busy), .overrun(b_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges since the last reset release: edge k leaves cyc == k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic push_a(input logic [SW-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [SW-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q_b.push_back(e);
  endtask

  // Called at a falling edge; an input driven here is seen at edge n+1.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (a_valid) begin
      if (q_a.size() == 0) begin
        check("a_spurious_valid", a_valid, 1'b0);
      end else begin
        e_a = q_a.pop_front();
        check("a_ldata", a_ldata, e_a.data);
        check("a_rdata", a_rdata, e_a.data);
        check("a_valid_cycle", cyc, e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (b_valid) begin
      if (q_b.size() == 0) begin
        check("b_spurious_valid", b_valid, 1'b0);
      end else begin
        e_b = q_b.pop_front();
        check("b_ldata", b_ldata, e_b.data);
        check("b_rdata", b_rdata, e_b.data);
        check("b_valid_cycle", cyc, e_b.cyc);
      end
    end
  end

  task automatic idle_inputs();
    a_key_on = '0; a_req = 1'b0; a_cfg_we = 1'b0; a_cfg_voice = '0;
    a_cfg_half = '0; a_vol = '0;
    b_key_on = '0; b_req = 1'b0; b_cfg_we = 1'b0; b_cfg_voice = '0;
    b_cfg_half = '0; b_vol = '0;
  endtask

  // Ends at a falling edge with reset just released and cyc == 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_a_ldata",   a_ldata,   16'h0000);
    check("rst_a_rdata",   a_rdata,   16'h0000);
    check("rst_a_valid",   a_valid,   1'b0);
    check("rst_a_busy",    a_busy,    1'b0);
    check("rst_a_overrun", a_overrun, 1'b0);
    check("rst_b_ldata",   b_ldata,   16'h0000);
    check("rst_b_busy",    b_busy,    1'b0);
    check("rst_b_overrun", b_overrun, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("a_all_samples_seen", q_a.size(), 0);
    check("b_all_samples_seen", q_b.size(), 0);
  endtask

  // Voice 0 (half 3) toggles at edges 4,8,12,..; a request at edge E uses
  // the phase from before E; its sample appears at edge E+5.
  task automatic scen_single_and_silent();
    a_key_on = 4'b0001;
    a_req    = 1'b1;
    push_a(16'hF000, 6);        // E=1, phase 0 -> -0x1000
    wait_cyc(1);  a_req = 1'b0;
    wait_cyc(13); a_req = 1'b1;
    push_a(16'h1000, 19);       // E=14, phase 1 after edge 12
    wait_cyc(14); a_req = 1'b0;
    a_key_on = 4'b1111;         // after the snapshot: must not matter
    wait_cyc(20); a_key_on = 4'b0100;
    wait_cyc(21); a_req = 1'b1;
    push_a(16'h0000, 27);       // voice 2 keyed but half 0 -> silent
    wait_cyc(22); a_req = 1'b0;
    wait_cyc(27);
    a_cfg_we = 1'b1; a_cfg_voice = 2'd2; a_cfg_half = 8'd2;   // edge 28
    wait_cyc(28); a_cfg_we = 1'b0;
    // Voice 2 now toggles at edges 31,34,37,40,..
    wait_cyc(29); a_req = 1'b1;
    push_a(16'hF000, 35);       // E=30, phase 0
    wait_cyc(30); a_req = 1'b0;
    wait_cyc(39); a_req = 1'b1;
    push_a(16'h1000, 45);       // E=40, phase 1 after three toggles
    wait_cyc(40); a_req = 1'b0;
  endtask

  // All four voices retuned to half 4 at edges 1..4; voice k then toggles
  // at edges k+6, k+11, k+16, ... so all are 0 before edge 6 and all are 1
  // after edges 19 and 20.
  task automatic scen_saturate();
    b_key_on    = 4'b1111;
    b_cfg_we    = 1'b1;
    b_cfg_half  = 8'd4;
    b_cfg_voice = 2'd0;
    for (int v = 1; v < NV; v++) begin
      wait_cyc(v);
      b_cfg_voice = 2'(v);
    end
    wait_cyc(4);  b_cfg_we = 1'b0; b_req = 1'b1;
    push_b(16'h8000, 10);       // E=5: 4 x -0x3000 clamps low
    wait_cyc(5);  b_req = 1'b0;
    wait_cyc(19); b_req = 1'b1;
    push_b(16'h7FFF, 25);       // E=20: 4 x +0x3000 clamps high
    wait_cyc(20); b_req = 1'b0;
  endtask

  // Requests at edges 1, 3, 5: the second waits in pending, the third is
  // dropped. Outputs at edges 6 and 13 (7 apart).
  task automatic scen_overrun();
    a_key_on = 4'b0001;
    a_req    = 1'b1;
    push_a(16'hF000, 6);
    wait_cyc(1); a_req = 1'b0;
    wait_cyc(2); a_req = 1'b1;
    push_a(16'h1000, 13);       // serviced at edge 8, phase 1 after edge 7
    wait_cyc(3); a_req = 1'b0;
    check("ovr_busy_in_accum", a_busy, 1'b1);
    check("ovr_not_yet", a_overrun, 1'b0);
    wait_cyc(4); a_req = 1'b1;
    wait_cyc(5); a_req = 1'b0;
    check("ovr_set", a_overrun, 1'b1);
    wait_cyc(6);
    check("ovr_idle_after_sat", a_busy, 1'b0);
    wait_cyc(30);
    check("ovr_sticky", a_overrun, 1'b1);
  endtask

  task automatic scen_volume_and_abort();
    a_key_on = 4'b0001;
    a_vol    = 2'd2;
    a_req    = 1'b1;
    push_a(16'hFC00, 6);        // -0x1000 >>> 2
    wait_cyc(1);  a_req = 1'b0;
    wait_cyc(9);  a_req = 1'b1; // E=10, ACCUM over edges 11..14
    wait_cyc(10); a_req = 1'b0;
    check("vol_ldata_holds", a_ldata, 16'hFC00);
    wait_cyc(12);
    check("abort_busy_before", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_ldata", a_ldata, 16'h0000);
    check("abort_rdata", a_rdata, 16'h0000);
    check("abort_busy",  a_busy,  1'b0);
    check("abort_valid", a_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(15);
    check("abort_ldata_after", a_ldata, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    do_reset();
    fork
      scen_single_and_silent();
      scen_saturate();
    join
    drain();

    do_reset();
    scen_overrun();
    drain();

    do_reset();
    scen_volume_and_abort();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
